// File: rtl/mcpu_soc_mmio_fabric_pkg.sv
// Shared types and constants for the MCPU SoC MMIO fabric.
package mcpu_soc_mmio_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [18:0] REGION_GPIO    = 19'd0;
    localparam logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF;
    localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

    // Expand per-byte write enables into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] wren);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{wren[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mcpu_soc_mmio_fabric_if.sv
// CPU-side request/response bus of the MMIO fabric.
interface mcpu_soc_mmio_fabric_if;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [28:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wren;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rdata;
    logic        cpu_rsp_err;

    modport master (
        output cpu_req_valid, cpu_addr, cpu_wdata, cpu_wren,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rdata, cpu_rsp_err
    );

    modport slave (
        input  cpu_req_valid, cpu_addr, cpu_wdata, cpu_wren,
        output cpu_req_ready, cpu_rsp_valid, cpu_rdata, cpu_rsp_err
    );
endinterface

// File: rtl/mcpu_soc_mmio_fabric_gpio.sv
// Region-0 GPIO bank: output registers with byte-masked writes and input read mux.
// Define MMIO_GPIO_SYNC_EN to pass gpio_in through a two-flop synchronizer.
module mcpu_soc_mmio_gpio
    import mcpu_soc_mmio_pkg::*;
#(
    parameter int GPIO_WORDS = 2,
    localparam int IDXW = (GPIO_WORDS > 1) ? $clog2(GPIO_WORDS) : 1
) (
    input  logic                    clkrst_core_clk,
    input  logic                    clkrst_core_rst,
    input  logic                    wr_en_i,
    input  logic [IDXW-1:0]         idx_i,
    input  logic [31:0]             wdata_i,
    input  logic [3:0]              wren_i,
    output logic [31:0]             rdata_o,
    input  logic [GPIO_WORDS*32-1:0] gpio_in_i,
    output logic [GPIO_WORDS*32-1:0] gpio_out_o
);

    logic [31:0]             out_q [GPIO_WORDS];
    logic [GPIO_WORDS*32-1:0] gin_eff;
    logic [31:0]             mask;

    assign mask = byte_mask(wren_i);

`ifdef MMIO_GPIO_SYNC_EN
    logic [GPIO_WORDS*32-1:0] sync1_q, sync2_q;

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in_i;
            sync2_q <= sync1_q;
        end
    end

    assign gin_eff = sync2_q;
`else
    assign gin_eff = gpio_in_i;
`endif

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            for (int i = 0; i < GPIO_WORDS; i++) out_q[i] <= '0;
        end else if (wr_en_i) begin
            for (int i = 0; i < GPIO_WORDS; i++) begin
                if (idx_i == IDXW'(i)) out_q[i] <= (wdata_i & mask) | (out_q[i] & ~mask);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < GPIO_WORDS; gi++) begin : g_out
            assign gpio_out_o[gi*32 +: 32] = out_q[gi];
        end
    endgenerate

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < GPIO_WORDS; i++) begin
            if (idx_i == IDXW'(i)) rdata_o = gin_eff[i*32 +: 32];
        end
    end

endmodule

// File: rtl/mcpu_soc_mmio_fabric.sv
// Registered MMIO fabric: region 0 = GPIO bank, regions 1..NUM_SLOTS-1 = req/ack slots with timeout.
// Optional MMIO_GPIO_SYNC_EN adds a two-flop synchronizer on gpio_in (see gpio sub-module).
module mcpu_soc_mmio_fabric
    import mcpu_soc_mmio_pkg::*;
#(
    parameter int NUM_SLOTS  = 4,
    parameter int GPIO_WORDS = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                     clkrst_core_clk,
    input  logic                     clkrst_core_rst,
    mcpu_soc_mmio_fabric_if.slave    cpu,
    input  logic [GPIO_WORDS*32-1:0] gpio_in_i,
    output logic [GPIO_WORDS*32-1:0] gpio_out_o,
    output logic [NUM_SLOTS-1:0]     slot_req_o,
    output logic [9:0]               slot_addr_o,
    output logic [31:0]              slot_wdata_o,
    output logic [3:0]               slot_wren_o,
    input  logic [NUM_SLOTS-1:0]     slot_ack_i,
    input  logic [NUM_SLOTS*32-1:0]  slot_rdata_i
);

    localparam int SW   = $clog2(NUM_SLOTS);
    localparam int IDXW = (GPIO_WORDS > 1) ? $clog2(GPIO_WORDS) : 1;

    state_t               state_q;
    logic [NUM_SLOTS-1:0] slot_req_q;
    logic [SW-1:0]        slot_idx_q;
    logic [9:0]           slot_addr_q;
    logic [31:0]          slot_wdata_q;
    logic [3:0]           slot_wren_q;
    logic [7:0]           cnt_q;
    logic [31:0]          rdata_q;
    logic                 err_q;

    logic [18:0] region;
    logic [9:0]  offs;
    logic        is_gpio, is_slot, gpio_hit, gpio_wr;
    logic [31:0] gpio_rdata;
    logic [31:0] slot_rd_w [NUM_SLOTS];

    assign region   = cpu.cpu_addr[28:10];
    assign offs     = cpu.cpu_addr[9:0];
    assign is_gpio  = (region == REGION_GPIO);
    assign is_slot  = !is_gpio && (region < 19'(NUM_SLOTS));
    assign gpio_hit = is_gpio && (offs < 10'(GPIO_WORDS));
    // The GPIO bank commits on the accepting edge itself.
    assign gpio_wr  = (state_q == S_IDLE) && cpu.cpu_req_valid && gpio_hit && (|cpu.cpu_wren);

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_rd
            assign slot_rd_w[gi] = slot_rdata_i[gi*32 +: 32];
        end
    endgenerate

    mcpu_soc_mmio_gpio #(.GPIO_WORDS(GPIO_WORDS)) u_gpio (
        .clkrst_core_clk (clkrst_core_clk),
        .clkrst_core_rst (clkrst_core_rst),
        .wr_en_i         (gpio_wr),
        .idx_i           (offs[IDXW-1:0]),
        .wdata_i         (cpu.cpu_wdata),
        .wren_i          (cpu.cpu_wren),
        .rdata_o         (gpio_rdata),
        .gpio_in_i       (gpio_in_i),
        .gpio_out_o      (gpio_out_o)
    );

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q      <= S_IDLE;
            slot_req_q   <= '0;
            slot_idx_q   <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            slot_wren_q  <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu.cpu_req_valid) begin
                        if (is_gpio) begin
                            state_q <= S_RESP;
                            rdata_q <= gpio_hit ? gpio_rdata : UNMAPPED_RDATA;
                            err_q   <= !gpio_hit;
                        end else if (is_slot) begin
                            state_q      <= S_WAIT;
                            slot_idx_q   <= region[SW-1:0];
                            slot_req_q   <= NUM_SLOTS'(1) << region[SW-1:0];
                            slot_addr_q  <= offs;
                            slot_wdata_q <= cpu.cpu_wdata;
                            slot_wren_q  <= cpu.cpu_wren;
                            cnt_q        <= '0;
                        end else begin
                            state_q <= S_RESP;
                            rdata_q <= UNMAPPED_RDATA;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // Ack is tested first so an ack in the final cycle beats the timeout.
                    if (slot_ack_i[slot_idx_q]) begin
                        state_q    <= S_RESP;
                        slot_req_q <= '0;
                        rdata_q    <= slot_rd_w[slot_idx_q];
                        err_q      <= 1'b0;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        state_q    <= S_RESP;
                        slot_req_q <= '0;
                        rdata_q    <= TIMEOUT_RDATA;
                        err_q      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu.cpu_req_ready = (state_q == S_IDLE);
    assign cpu.cpu_rsp_valid = (state_q == S_RESP);
    assign cpu.cpu_rdata     = rdata_q;
    assign cpu.cpu_rsp_err   = err_q;
    assign slot_req_o        = slot_req_q;
    assign slot_addr_o       = slot_addr_q;
    assign slot_wdata_o      = slot_wdata_q;
    assign slot_wren_o       = slot_wren_q;

endmodule

// File: tb/tb_mcpu_soc_mmio_fabric.sv
// Self-checking bench for mcpu_soc_mmio_fabric: vector table, corner sequences, random vs. model.
module tb_mcpu_soc_mmio_fabric;

    localparam int NS = 4;
    localparam int GW = 2;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [GW*32-1:0] gpio_in, gpio_out;
    logic [NS-1:0]    slot_req, slot_ack;
    logic [9:0]       slot_addr;
    logic [31:0]      slot_wdata;
    logic [3:0]       slot_wren;
    logic [NS*32-1:0] slot_rdata;

    mcpu_soc_mmio_fabric_if cpu_if();

    mcpu_soc_mmio_fabric #(.NUM_SLOTS(NS), .GPIO_WORDS(GW), .TIMEOUT(TO)) dut (
        .clkrst_core_clk (clk),
        .clkrst_core_rst (rst),
        .cpu             (cpu_if),
        .gpio_in_i       (gpio_in),
        .gpio_out_o      (gpio_out),
        .slot_req_o      (slot_req),
        .slot_addr_o     (slot_addr),
        .slot_wdata_o    (slot_wdata),
        .slot_wren_o     (slot_wren),
        .slot_ack_i      (slot_ack),
        .slot_rdata_i    (slot_rdata)
    );

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] gout_m [GW];

    typedef struct {
        logic [28:0] a;
        logic [31:0] wd;
        logic [3:0]  we;
        logic [63:0] gin;
        int          dly;
        logic [31:0] ackd;
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
        int          e_reqc;
        logic [63:0] e_gout;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: the response follows from region/offset rules alone.
    task automatic model(input logic [28:0] a, input logic [31:0] wd, input logic [3:0] we,
                         input int dly, input logic [NS*32-1:0] srd,
                         output logic [31:0] rd, output logic er, output int lat, output int reqc);
        int region, offs;
        region = int'(a >> 10);
        offs   = int'(a & 29'h3FF);
        if (region == 0) begin
            lat = 1; reqc = 0;
            if (offs < GW) begin
                rd = gpio_in[offs*32 +: 32];
                er = 1'b0;
                for (int b = 0; b < 4; b++)
                    if (we[b]) gout_m[offs][8*b +: 8] = wd[8*b +: 8];
            end else begin
                rd = 32'h0; er = 1'b1;
            end
        end else if (region < NS) begin
            if (dly >= 1 && dly <= TO) begin
                rd = srd[region*32 +: 32]; er = 1'b0; reqc = dly;
            end else begin
                rd = 32'hDEAD_BEEF; er = 1'b1; reqc = TO;
            end
            lat = reqc + 1;
        end else begin
            rd = 32'h0; er = 1'b1; lat = 1; reqc = 0;
        end
    endtask

    // Issue one access, act as the slot responder, and return what the fabric did.
    task automatic do_access(input logic [28:0] a, input logic [31:0] wd, input logic [3:0] we,
                             input int dly, input logic [NS*32-1:0] srd, input bit stray,
                             output logic [31:0] rd, output logic er, output int lat,
                             output int reqc, output bit fields_ok);
        int  waited;
        bit  got;
        logic [NS-1:0] exp_req;
        exp_req = ((a >> 10) < NS) ? NS'(1) << (a >> 10) : '0;
        repeat (3) @(negedge clk);
        cpu_if.cpu_req_valid = 1'b1;
        cpu_if.cpu_addr      = a;
        cpu_if.cpu_wdata     = wd;
        cpu_if.cpu_wren      = we;
        slot_rdata           = srd;
        waited = 0;
        while (!cpu_if.cpu_req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!cpu_if.cpu_req_ready) chk("accept_ready", 64'(cpu_if.cpu_req_ready), 64'd1);
        @(posedge clk);
        #1 cpu_if.cpu_req_valid = 1'b0;
        got = 1'b0; lat = -1; reqc = 0; fields_ok = 1'b1; rd = 'x; er = 'x;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            slot_ack = '0;
            if (cpu_if.cpu_rsp_valid) begin
                got = 1'b1; lat = c;
                rd = cpu_if.cpu_rdata; er = cpu_if.cpu_rsp_err;
            end else begin
                if (slot_req != '0) begin
                    reqc++;
                    if (slot_req !== exp_req || slot_addr !== a[9:0] ||
                        slot_wdata !== wd || slot_wren !== we) fields_ok = 1'b0;
                    if (reqc == dly) slot_ack = slot_req;
                end
                if (stray) slot_ack = slot_ack | (NS'($urandom) & ~slot_req);
            end
        end
        slot_ack = '0;
        @(negedge clk);
        chk("rsp_pulse", {62'd0, cpu_if.cpu_rsp_valid, cpu_if.cpu_req_ready}, 64'd1);
    endtask

    task automatic run_model(input string tag, input logic [28:0] a, input logic [31:0] wd,
                             input logic [3:0] we, input int dly, input logic [NS*32-1:0] srd,
                             input bit stray);
        logic [31:0] rd, e_rd;
        logic er, e_er;
        int lat, reqc, e_lat, e_reqc;
        bit fok;
        model(a, wd, we, dly, srd, e_rd, e_er, e_lat, e_reqc);
        do_access(a, wd, we, dly, srd, stray, rd, er, lat, reqc, fok);
        $display("%s a=%h we=%h dly=%0d rd=%h err=%0d lat=%0d req=%0d", tag, a, we, dly, rd, er, lat, reqc);
        chk({tag, "_rdata"}, 64'(rd), 64'(e_rd));
        chk({tag, "_err"}, 64'(er), 64'(e_er));
        chk({tag, "_lat"}, 64'(lat), 64'(e_lat));
        chk({tag, "_reqc"}, 64'(reqc), 64'(e_reqc));
        chk({tag, "_slot_fields"}, 64'(fok), 64'd1);
        chk({tag, "_gpio_out"}, 64'(gpio_out), {gout_m[1], gout_m[0]});
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic er;
        int lat, reqc, quiet;
        bit fok;

        tbl[0] = '{29'h1,        32'h1234_5678, 4'b0101, {32'h5555_AAAA, 32'hCAFE_F00D}, 0, 32'h0,
                   32'h5555_AAAA, 1'b0, 1,  0,  {32'h0034_0078, 32'h0}};
        tbl[1] = '{29'h0,        32'h0,         4'b0000, {32'h5555_AAAA, 32'hCAFE_F00D}, 0, 32'h0,
                   32'hCAFE_F00D, 1'b0, 1,  0,  {32'h0034_0078, 32'h0}};
        tbl[2] = '{29'h800,      32'h0,         4'b0000, 64'h0, 3,  32'hA5A5_0001,
                   32'hA5A5_0001, 1'b0, 4,  3,  {32'h0034_0078, 32'h0}};
        tbl[3] = '{29'hC05,      32'h0,         4'b0000, 64'h0, 0,  32'h1111_2222,
                   32'hDEAD_BEEF, 1'b1, 16, 15, {32'h0034_0078, 32'h0}};
        tbl[4] = '{29'hC05,      32'h0,         4'b0000, 64'h0, 15, 32'h1111_2222,
                   32'h1111_2222, 1'b0, 16, 15, {32'h0034_0078, 32'h0}};
        tbl[5] = '{29'h1C00_0000, 32'hFFFF_FFFF, 4'b1111, 64'h0, 0, 32'h0,
                   32'h0,         1'b1, 1,  0,  {32'h0034_0078, 32'h0}};
        tbl[6] = '{29'h2,        32'hFFFF_FFFF, 4'b1111, 64'h0, 0,  32'h0,
                   32'h0,         1'b1, 1,  0,  {32'h0034_0078, 32'h0}};
        tbl[7] = '{29'h0,        32'hDEAD_0001, 4'b1111, {32'h5555_AAAA, 32'hCAFE_F00D}, 0, 32'h0,
                   32'hCAFE_F00D, 1'b0, 1,  0,  {32'h0034_0078, 32'hDEAD_0001}};
        tbl[8] = '{29'h405,      32'h0,         4'b0011, 64'h0, 1,  32'h0000_0077,
                   32'h0000_0077, 1'b0, 2,  1,  {32'h0034_0078, 32'hDEAD_0001}};
        tbl[9] = '{29'h1000,     32'h0,         4'b0000, 64'h0, 0,  32'h0,
                   32'h0,         1'b1, 1,  0,  {32'h0034_0078, 32'hDEAD_0001}};

        cpu_if.cpu_req_valid = 1'b0;
        cpu_if.cpu_addr      = '0;
        cpu_if.cpu_wdata     = '0;
        cpu_if.cpu_wren      = '0;
        gpio_in    = '0;
        slot_ack   = '0;
        slot_rdata = '0;

        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 64'(cpu_if.cpu_rsp_valid), 64'd0);
        chk("reset_rdata",     64'(cpu_if.cpu_rdata),     64'd0);
        chk("reset_err",       64'(cpu_if.cpu_rsp_err),   64'd0);
        chk("reset_slot_req",  64'(slot_req),             64'd0);
        chk("reset_gpio_out",  64'(gpio_out),             64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            gpio_in = tbl[i].gin;
            do_access(tbl[i].a, tbl[i].wd, tbl[i].we, tbl[i].dly, {NS{tbl[i].ackd}}, 1'b0,
                      rd, er, lat, reqc, fok);
            $display("vec%0d a=%h rd=%h err=%0d lat=%0d req=%0d gout=%h", i, tbl[i].a, rd, er, lat, reqc, gpio_out);
            chk($sformatf("vec%0d_rdata", i), 64'(rd),   64'(tbl[i].e_rd));
            chk($sformatf("vec%0d_err", i),   64'(er),   64'(tbl[i].e_err));
            chk($sformatf("vec%0d_lat", i),   64'(lat),  64'(tbl[i].e_lat));
            chk($sformatf("vec%0d_reqc", i),  64'(reqc), 64'(tbl[i].e_reqc));
            chk($sformatf("vec%0d_fields", i), 64'(fok), 64'd1);
            chk($sformatf("vec%0d_gpio_out", i), 64'(gpio_out), tbl[i].e_gout);
        end
        gout_m[0] = tbl[9].e_gout[31:0];
        gout_m[1] = tbl[9].e_gout[63:32];

`ifdef MMIO_GPIO_SYNC_EN
        // An input change one cycle before accept must not be visible yet.
        gpio_in = {32'h0, 32'h1111_0000};
        repeat (4) @(negedge clk);
        gpio_in = {32'h0, 32'h2222_0000};
        @(negedge clk);
        cpu_if.cpu_req_valid = 1'b1;
        cpu_if.cpu_addr = 29'h0;
        cpu_if.cpu_wren = 4'b0000;
        @(posedge clk);
        #1 cpu_if.cpu_req_valid = 1'b0;
        @(negedge clk);
        $display("sync_late rd=%h", cpu_if.cpu_rdata);
        chk("sync_late_rdata", 64'(cpu_if.cpu_rdata), 64'h1111_0000);
        @(negedge clk);
`endif

        // Reset while a slot access is outstanding.
        @(negedge clk);
        cpu_if.cpu_req_valid = 1'b1;
        cpu_if.cpu_addr = 29'h803;
        cpu_if.cpu_wren = 4'b0000;
        @(posedge clk);
        #1 cpu_if.cpu_req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_wait_req", 64'(slot_req), 64'h4);
        #2 rst = 1'b1;
        #1;
        $display("reset_in_wait slot_req=%h rsp_valid=%0d", slot_req, cpu_if.cpu_rsp_valid);
        chk("rst_async_slot_req", 64'(slot_req), 64'd0);
        chk("rst_async_rsp_valid", 64'(cpu_if.cpu_rsp_valid), 64'd0);
        chk("rst_gpio_out", 64'(gpio_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_if.cpu_rsp_valid || slot_req != '0) quiet++;
        end
        chk("post_rst_quiet", 64'(quiet), 64'd0);
        gout_m[0] = '0;
        gout_m[1] = '0;
        run_model("post_rst", 29'h805, 32'h0, 4'b0000, 2, {32'h4, 32'h3, 32'hBEEF_0002, 32'h1}, 1'b0);

        for (int i = 0; i < 150; i++) begin
            logic [28:0] a;
            int r;
            r = $urandom_range(0, 9);
            if (r < 4)      a = 29'($urandom_range(0, 3));
            else if (r < 8) a = {19'($urandom_range(1, NS)), 10'($urandom)};
            else            a = {19'($urandom), 10'($urandom)};
            gpio_in = {$urandom, $urandom};
            run_model($sformatf("rnd%0d", i), a, $urandom, 4'($urandom), $urandom_range(0, 20),
                      {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
